// File: rtl/serial_adder_if.sv
// Operand/result bundle for the digit-serial adder: the requester (master) drives
// operands and start, and the adder (slave) answers with busy/done and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: a DIGIT-bit ripple slice with a registered carry walks
// the operands LSB-first over WIDTH/DIGIT cycles; results are held until the next completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic          clk,
    input logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             c_r;
    logic [CW-1:0]    k;

    // Returns {carry into the digit's top bit, carry out, DIGIT sum bits}.
    function automatic logic [DIGIT+1:0] digit_add(input logic [DIGIT-1:0] x,
                                                   input logic [DIGIT-1:0] y,
                                                   input logic             ci);
        logic [DIGIT-1:0] s;
        logic             c;
        logic             c_top;
        s     = '0;
        c     = ci;
        c_top = ci;
        for (int i = 0; i < DIGIT; i++) begin
            c_top = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c_top, c, s};
    endfunction

    logic [DIGIT+1:0]       slice;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_nxt;

    // New digit enters at the top so that after N shifts the LSB digit sits at bit 0.
    always_comb begin
        slice   = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], c_r);
        res_cat = {slice[DIGIT-1:0], res_r};
        res_nxt = WIDTH'(res_cat >> DIGIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            res_r        <= '0;
            c_r          <= 1'b0;
            k            <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sum      <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r      <= bus.a;
                        b_r      <= bus.sub ? ~bus.b : bus.b;
                        c_r      <= bus.cin ^ bus.sub;
                        res_r    <= '0;
                        k        <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    res_r <= res_nxt;
                    c_r   <= slice[DIGIT];
                    k     <= k + CW'(1);
                    if (k == K_LAST) begin
                        bus.sum      <= res_nxt;
                        bus.cout     <= slice[DIGIT];
                        bus.overflow <= slice[DIGIT+1] ^ slice[DIGIT];
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four configurations (W1D1, W8D1, W8D4, W12D3) share one
// clock/reset; expected results are queued at start and compared when done pulses.
module tb_serial_adder;

    localparam int NU = 4;

    function automatic int cfg_w(input int g);
        case (g)
            0:       return 1;
            1:       return 8;
            2:       return 8;
            default: return 12;
        endcase
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            0:       return 1;
            1:       return 1;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int          u;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sbq[$];

    logic        start_u[NU];
    logic        sub_u[NU];
    logic        cin_u[NU];
    logic [15:0] a_u[NU];
    logic [15:0] b_u[NU];
    logic [15:0] sum_u[NU];
    logic        busy_u[NU];
    logic        done_u[NU];
    logic        cout_u[NU];
    logic        ovf_u[NU];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NU; g++) begin : g_unit
        localparam int W = cfg_w(g);
        localparam int D = cfg_d(g);
        localparam int N = W / D;
        exp_t e;

        serial_adder_if #(.WIDTH(W)) bus ();
        assign bus.start = start_u[g];
        assign bus.sub   = sub_u[g];
        assign bus.cin   = cin_u[g];
        assign bus.a     = a_u[g][W-1:0];
        assign bus.b     = b_u[g][W-1:0];
        assign sum_u[g]  = 16'(bus.sum);
        assign busy_u[g] = bus.busy;
        assign done_u[g] = bus.done;
        assign cout_u[g] = bus.cout;
        assign ovf_u[g]  = bus.overflow;

        serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        always @(negedge clk) begin
            if (done_u[g]) begin
                if (sbq.size() == 0 || sbq[0].u != g) begin
                    check($sformatf("u%0d unexpected done", g), 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("u%0d sum", g), 32'(sum_u[g]), 32'(e.sum));
                    check($sformatf("u%0d cout", g), 32'(cout_u[g]), 32'(e.cout));
                    check($sformatf("u%0d ovf", g), 32'(ovf_u[g]), 32'(e.ovf));
                    check($sformatf("u%0d latency", g), 32'(cyc - e.t0), 32'(N));
                end
            end
        end
    end

    // Independent reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input int u, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input int t0);
        exp_t   r;
        longint m, ua, ub, sa, sb, ur, sr;
        m  = longint'(1) << cfg_w(u);
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!sub) begin
            ur     = ua + ub + longint'(cin);
            sr     = sa + sb + longint'(cin);
            r.cout = (ur >= m);
        end else begin
            ur     = ua - ub - longint'(cin);
            sr     = sa - sb - longint'(cin);
            r.cout = (ur >= 0);
        end
        r.sum = 16'((ur + 2 * m) % m);
        r.ovf = (sr < -(m / 2)) || (sr >= m / 2);
        r.u   = u;
        r.t0  = t0;
        return r;
    endfunction

    task automatic drive(input int u, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        a_u[u]   = a;
        b_u[u]   = b;
        cin_u[u] = cin;
        sub_u[u] = sub;
    endtask

    task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
        int n;
        int bc;
        int nn;
        nn = cfg_w(u) / cfg_d(u);
        @(negedge clk);
        drive(u, a, b, cin, sub);
        start_u[u] = 1'b1;
        sbq.push_back(model(u, a, b, cin, sub, cyc + 1));
        @(negedge clk);
        start_u[u] = 1'b0;
        drive(u, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        n  = 0;
        bc = 0;
        while (!done_u[u] && n < 64) begin
            if (busy_u[u]) bc++;
            @(negedge clk);
            n++;
        end
        if (!done_u[u]) begin
            check($sformatf("u%0d done timeout", u), 32'd0, 32'd1);
        end else begin
            if (busy_u[u]) bc++;
            check($sformatf("u%0d busy cycles", u), 32'(bc), 32'(nn + 1));
            @(negedge clk);
            check($sformatf("u%0d done one-cycle", u), 32'(done_u[u]), 32'd0);
            check($sformatf("u%0d busy after done", u), 32'(busy_u[u]), 32'd0);
        end
    endtask

    task automatic vec8(input int u);
        run_op(u, 16'hFF, 16'h01, 1'b0, 1'b0);
        run_op(u, 16'h7F, 16'h01, 1'b0, 1'b0);
        run_op(u, 16'h05, 16'h07, 1'b0, 1'b1);
        run_op(u, 16'h80, 16'h01, 1'b0, 1'b1);
        run_op(u, 16'h05, 16'h02, 1'b1, 1'b1);
        run_op(u, 16'h80, 16'h80, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        for (int i = 0; i < NU; i++) begin
            start_u[i] = 1'b0;
            drive(i, 16'h0, 16'h0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NU; i++) begin
            check($sformatf("u%0d reset busy", i), 32'(busy_u[i]), 32'd0);
            check($sformatf("u%0d reset done", i), 32'(done_u[i]), 32'd0);
            check($sformatf("u%0d reset sum", i), 32'(sum_u[i]), 32'd0);
            check($sformatf("u%0d reset cout/ovf", i), 32'({cout_u[i], ovf_u[i]}), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(0, 16'(i >> 2), 16'((i >> 1) & 1), 1'(i), 1'b0);
        for (int i = 0; i < 8; i++) run_op(0, 16'(i >> 2), 16'((i >> 1) & 1), 1'(i), 1'b1);

        vec8(1);
        vec8(2);

        // Restarts in RUN and in the DONE cycle must be ignored.
        @(negedge clk);
        drive(1, 16'h3C, 16'h5A, 1'b1, 1'b0);
        start_u[1] = 1'b1;
        sbq.push_back(model(1, 16'h3C, 16'h5A, 1'b1, 1'b0, cyc + 1));
        @(negedge clk);
        start_u[1] = 1'b0;
        @(negedge clk);
        drive(1, 16'hAA, 16'h11, 1'b0, 1'b1);
        start_u[1] = 1'b1;
        @(negedge clk);
        start_u[1] = 1'b0;
        for (int i = 0; i < 20 && !done_u[1]; i++) @(negedge clk);
        check("u1 ignore: done seen", 32'(done_u[1]), 32'd1);
        drive(1, 16'h99, 16'h66, 1'b1, 1'b1);
        start_u[1] = 1'b1;
        @(negedge clk);
        start_u[1] = 1'b0;
        repeat (14) @(negedge clk);
        check("u1 ignore: scoreboard drained", 32'(sbq.size()), 32'd0);

        // Held start: second op accepted N+2 edges after the first.
        @(negedge clk);
        drive(1, 16'h12, 16'h34, 1'b0, 1'b0);
        start_u[1] = 1'b1;
        t0 = cyc + 1;
        sbq.push_back(model(1, 16'h12, 16'h34, 1'b0, 1'b0, t0));
        @(negedge clk);
        drive(1, 16'hF0, 16'h0F, 1'b1, 1'b1);
        sbq.push_back(model(1, 16'hF0, 16'h0F, 1'b1, 1'b1, t0 + 10));
        repeat (10) @(negedge clk);
        start_u[1] = 1'b0;
        repeat (14) @(negedge clk);
        check("u1 held start: scoreboard drained", 32'(sbq.size()), 32'd0);

        // Reset at RUN cycle 3 aborts with no done.
        @(negedge clk);
        drive(1, 16'hFF, 16'hFF, 1'b1, 1'b0);
        start_u[1] = 1'b1;
        @(negedge clk);
        start_u[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("u1 abort busy", 32'(busy_u[1]), 32'd0);
        check("u1 abort done", 32'(done_u[1]), 32'd0);
        check("u1 abort sum", 32'(sum_u[1]), 32'd0);
        check("u1 abort cout/ovf", 32'({cout_u[1], ovf_u[1]}), 32'd0);
        repeat (12) @(negedge clk);
        check("u1 abort no busy", 32'(busy_u[1]), 32'd0);
        run_op(1, 16'h7F, 16'h01, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++)
            run_op(3, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        repeat (4) @(negedge clk);
        check("scoreboard empty at end", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
